// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush controls and counters out.
// The master drives pipeline status; the slave is the hazard controller.
interface pipe_hazard_ctrl_if;
   logic        memReadIDOut;
   logic [2:0]  rdIDOut;
   logic [2:0]  r1ID;
   logic [2:0]  r2ID;
   logic        usesR2ID;
   logic        takenEX;
   logic        haltReq;
   logic        resumeReq;
   logic        pcWrite;
   logic        ifidWrite;
   logic        flushIFID;
   logic        flushIDEX;
   logic        halted;
   logic [15:0] stallCount;
   logic [15:0] flushCount;

   modport master (
      output memReadIDOut, rdIDOut, r1ID, r2ID, usesR2ID, takenEX, haltReq, resumeReq,
      input  pcWrite, ifidWrite, flushIFID, flushIDEX, halted, stallCount, flushCount
   );

   modport slave (
      input  memReadIDOut, rdIDOut, r1ID, r2ID, usesR2ID, takenEX, haltReq, resumeReq,
      output pcWrite, ifidWrite, flushIFID, flushIDEX, halted, stallCount, flushCount
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, halt/resume FSM,
// and saturating event counters.
module pipe_hazard_ctrl (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic [0:0] {StRun, StHalt} stateT;

   stateT       state;
   logic [15:0] stallCnt;
   logic [15:0] flushCnt;
   logic        loadUse;

   // Register 0 is hardwired zero, so it never carries a dependency.
   always_comb begin
      loadUse = bus.memReadIDOut && (bus.rdIDOut != 3'd0) &&
                ((bus.rdIDOut == bus.r1ID) || (bus.usesR2ID && (bus.rdIDOut == bus.r2ID)));
   end

   always_comb begin
      bus.pcWrite   = 1'b0;
      bus.ifidWrite = 1'b0;
      bus.flushIFID = 1'b0;
      bus.flushIDEX = 1'b1;
      if (!rst) begin
         bus.flushIFID = 1'b1;
      end else if (state == StHalt) begin
         bus.flushIDEX = 1'b1;
      end else if (bus.takenEX) begin
         bus.pcWrite   = 1'b1;
         bus.ifidWrite = 1'b1;
         bus.flushIFID = 1'b1;
      end else if (!loadUse) begin
         bus.pcWrite   = 1'b1;
         bus.ifidWrite = 1'b1;
         bus.flushIDEX = 1'b0;
      end
      bus.halted     = rst && (state == StHalt);
      bus.stallCount = stallCnt;
      bus.flushCount = flushCnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= StRun;
         stallCnt <= 16'd0;
         flushCnt <= 16'd0;
      end else begin
         unique case (state)
            StRun: begin
               // Taken branch wins over a simultaneous load-use match.
               if (bus.takenEX) begin
                  if (flushCnt != 16'hFFFF) flushCnt <= flushCnt + 16'd1;
               end else if (loadUse) begin
                  if (stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
               end
               if (bus.haltReq) state <= StHalt;
            end
            StHalt: begin
               if (bus.resumeReq) state <= StRun;
            end
            default: state <= StRun;
         endcase
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- memReadIDOut  input  1  instruction currently in EX is a load.
- rdIDOut  input  3  destination register of the instruction in EX.
- r1ID  input  3  source register 1 of the instruction in ID.
- r2ID  input  3  source register 2 of the instruction in ID.
- usesR2ID  input  1  instruction in ID reads r2ID.
- takenEX  input  1  branch/jump resolved taken in EX this cycle.
- haltReq  input  1  request to drain and freeze the pipeline.
- resumeReq  input  1  request to leave the halted state.
- pcWrite  output  1  PC register update enable.
- ifidWrite  output  1  IF/ID register update enable.
- flushIFID  output  1  zero the IF/ID register this edge.
- flushIDEX  output  1  drives the flushIDEX input of the ID/EX register.
- halted  output  1  FSM is in HALT.
- stallCount  output  16  number of load-use stall cycles since reset.
- flushCount  output  16  number of taken-branch flush cycles since reset.

Function
REQ-002 FSM states SHALL be RUN and HALT, encoded in a state register.
REQ-003 loadUse SHALL equal memReadIDOut and (rdIDOut != 0) and ((rdIDOut == r1ID) or (usesR2ID and rdIDOut == r2ID)); register 0 never creates a hazard.
REQ-004 The control outputs SHALL be combinational from the state and the current-cycle inputs, with zero-cycle latency.
REQ-005 RUN with takenEX=1: pcWrite=1, ifidWrite=1, flushIFID=1, flushIDEX=1, flushCount increments.
REQ-006 RUN with takenEX=0 and loadUse=1: pcWrite=0, ifidWrite=0, flushIFID=0, flushIDEX=1 (one bubble), stallCount increments.
REQ-007 takenEX SHALL take priority over loadUse in the same cycle; only flushCount increments.
REQ-008 RUN with neither condition: pcWrite=1, ifidWrite=1, flushIFID=0, flushIDEX=0.
REQ-009 A load-use stall SHALL last exactly one cycle per hazard, because the bubble clears memReadIDOut the following cycle; the block holds no extra stall state.
REQ-010 RUN with haltReq=1 SHALL transition to HALT at the next edge. The current-cycle outputs still follow REQ-005 through REQ-008.
REQ-011 HALT: pcWrite=0, ifidWrite=0, flushIFID=0, flushIDEX=1, halted=1. takenEX and loadUse are ignored, and counters hold.
REQ-012 HALT with resumeReq=1 SHALL transition to RUN at the next edge. If haltReq and resumeReq are both 1 in HALT, resumeReq wins.
REQ-013 In RUN, resumeReq SHALL have no effect.
REQ-014 Both counters SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-015 rst=0 SHALL immediately, without waiting for a clock edge, force state=RUN, stallCount=0, flushCount=0.
REQ-016 While rst=0, outputs SHALL be pcWrite=0, ifidWrite=0, flushIFID=1, flushIDEX=1, halted=0.
REQ-017 Reset asserted mid-HALT or mid-stall SHALL abandon that operation. The first cycle after rst rises SHALL behave as RUN.

Verification
REQ-018 Load-use: memReadIDOut=1, rdIDOut=3, r1ID=3 for one cycle -> pcWrite=0, ifidWrite=0, flushIDEX=1; stallCount 0->1.
REQ-019 r0 and r2 gating:
- rdIDOut=0, r1ID=0, memReadIDOut=1 -> no stall.
- rdIDOut=5, r2ID=5, usesR2ID=0 -> no stall.
- rdIDOut=5, r2ID=5, usesR2ID=1 -> stall.
REQ-020 Simultaneous events: takenEX=1 together with a load-use match -> flushIFID=1, flushIDEX=1, pcWrite=1; flushCount +1, stallCount unchanged.
REQ-021 Halt/resume sequence:
- haltReq pulse -> halted=1 from next cycle, flushIDEX=1, pcWrite=0.
- takenEX pulses while halted -> counters unchanged.
- resumeReq pulse -> halted=0 the cycle after.
REQ-022 Saturation: preload via 65535 stall cycles, then one more hazard -> stallCount stays 16'hFFFF.
REQ-023 Reset mid-operation: rst pulled low asynchronously mid-cycle while in HALT with counters nonzero -> immediate halted=0, counters=0, flushIFID=1, flushIDEX=1; after rst rises, idle inputs -> pcWrite=1, no flushes.
